// File: rtl/l2_mem_arbiter.sv
// Two-client (I-side, D-side) line-request arbiter in front of one shared slow memory.
// Every output is registered; the FSM walks IDLE -> BUSY -> RESP for each granted request.

module l2_arb_port #(
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ready
);
  // ready is a one-cycle echo of the capture strobe, so it lands in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      ready <= 1'b0;
    end else begin
      ready <= cap;
      if (cap) rdata <= mem_rdata;
    end
  end
endmodule

module l2_mem_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int NCLI = 2;  // index 0 = I-side, 1 = D-side

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;

  logic [NCLI-1:0]             rd, wr, pend, cap, ready;
  logic [NCLI-1:0][ADDR_W-1:0] addr;
  logic [NCLI-1:0][LINE_W-1:0] wdata, rdata;
  logic                        win, win_nxt, last_grant;

  assign rd    = {d_read, i_read};
  assign wr    = {d_write, i_write};
  assign pend  = rd | wr;
  assign addr  = {d_addr, i_addr};
  assign wdata = {d_wdata, i_wdata};

  // D wins if alone, or on a tie under fixed priority, or when I was granted last.
  assign win_nxt = pend[1] & (~pend[0] | D_PRIORITY | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend)    state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A write wins over a read when both are raised by the same client.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win        <= 1'b0;
      last_grant <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (state == IDLE && |pend) begin
      win        <= win_nxt;
      last_grant <= win_nxt;
      mem_write  <= wr[win_nxt];
      mem_read   <= ~wr[win_nxt];
      mem_addr   <= addr[win_nxt];
      mem_wdata  <= wdata[win_nxt];
    end else if (state == BUSY && mem_ready) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end
  end

  genvar c;
  generate
    for (c = 0; c < NCLI; c++) begin : g_port
      assign cap[c] = (state == BUSY) & mem_ready & (win == 1'(c));
      l2_arb_port #(.LINE_W(LINE_W)) u_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (cap[c]),
        .mem_rdata (mem_rdata),
        .rdata     (rdata[c]),
        .ready     (ready[c])
      );
    end
  endgenerate

  assign i_rdata = rdata[0];
  assign d_rdata = rdata[1];
  assign i_ready = ready[0];
  assign d_ready = ready[1];
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench: instance A uses fixed D priority, instance B uses round-robin.
// Each instance has a small memory model that answers 5 cycles after a request appears.

module tb_l2_mem_arbiter;
  localparam int AW  = 28;
  localparam int LW  = 128;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // instance A signals
  logic          a_i_read, a_i_write, a_i_ready, a_d_read, a_d_write, a_d_ready;
  logic [AW-1:0] a_i_addr, a_d_addr, a_mem_addr;
  logic [LW-1:0] a_i_wdata, a_d_wdata, a_i_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_mem_read, a_mem_write, a_mem_ready;
  logic          a_auto, a_force, a_mr;
  logic [LW-1:0] a_rd;
  int            a_cnt;

  // instance B signals
  logic          b_i_read, b_i_write, b_i_ready, b_d_read, b_d_write, b_d_ready;
  logic [AW-1:0] b_i_addr, b_d_addr, b_mem_addr;
  logic [LW-1:0] b_i_wdata, b_d_wdata, b_i_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_mem_read, b_mem_write, b_mem_ready;
  logic          b_mr;
  int            b_cnt;

  assign a_mem_ready = a_mr | a_force;
  assign a_mem_rdata = a_rd;
  assign b_mem_ready = b_mr;
  assign b_mem_rdata = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .D_PRIORITY(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_read(a_i_read), .i_write(a_i_write), .i_addr(a_i_addr), .i_wdata(a_i_wdata),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_read(a_d_read), .d_write(a_d_write), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready)
  );

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .D_PRIORITY(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_read(b_i_read), .i_write(b_i_write), .i_addr(b_i_addr), .i_wdata(b_i_wdata),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_read(b_d_read), .d_write(b_d_write), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready)
  );

  // memory models: pulse ready on the LAT-th negedge a request is seen high
  initial begin
    a_mr = 1'b0; a_cnt = 0;
    forever begin
      @(negedge clk);
      a_mr = 1'b0;
      if (a_auto && (a_mem_read || a_mem_write)) begin
        if (a_cnt == LAT-1) begin a_mr = 1'b1; a_cnt = 0; end
        else a_cnt++;
      end else a_cnt = 0;
    end
  end

  initial begin
    b_mr = 1'b0; b_cnt = 0;
    forever begin
      @(negedge clk);
      b_mr = 1'b0;
      if (b_mem_read || b_mem_write) begin
        if (b_cnt == LAT-1) begin b_mr = 1'b1; b_cnt = 0; end
        else b_cnt++;
      end else b_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // wait for either ready on instance A; n=-1 on timeout
  task automatic wait_a(input int maxc, output int n, output logic gi, output logic gd);
    n = -1; gi = 1'b0; gd = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (a_i_ready || a_d_ready) begin
        n = k; gi = a_i_ready; gd = a_d_ready;
        break;
      end
    end
  endtask

  localparam logic [LW-1:0] L_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LW-1:0] L_WD   = 128'h11111111_11111111_22222222_22222222;

  int       n, ni, nd;
  logic     gi, gd;
  logic [1:0] who;

  initial begin
    a_i_read = 0; a_i_write = 0; a_i_addr = '0; a_i_wdata = '0;
    a_d_read = 0; a_d_write = 0; a_d_addr = '0; a_d_wdata = '0;
    b_i_read = 0; b_i_write = 0; b_i_addr = '0; b_i_wdata = '0;
    b_d_read = 0; b_d_write = 0; b_d_addr = '0; b_d_wdata = '0;
    a_auto = 1'b1; a_force = 1'b0; a_rd = L_DEAD;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", a_mem_read, 0);
    chk("rst_mem_write", a_mem_write, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_readys", {a_i_ready, a_d_ready}, 0);
    chk("rst_i_rdata", a_i_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single I read
    a_i_read = 1; a_i_addr = 28'h0000040;
    @(negedge clk);
    chk("ird_mem_read", a_mem_read, 1);
    chk("ird_mem_write", a_mem_write, 0);
    chk("ird_mem_addr", a_mem_addr, 28'h0000040);
    wait_a(20, n, gi, gd);
    chk("ird_latency", n, 5);
    chk("ird_gi", gi, 1);
    chk("ird_gd", gd, 0);
    chk("ird_rdata", a_i_rdata, L_DEAD);
    chk("ird_mem_drop", a_mem_read, 0);
    a_i_read = 0;
    @(negedge clk);
    chk("ird_pulse", a_i_ready, 0);

    // D write
    a_rd = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    a_d_write = 1; a_d_addr = 28'h0000123; a_d_wdata = L_WD;
    @(negedge clk);
    chk("dwr_mem_write", a_mem_write, 1);
    chk("dwr_mem_read", a_mem_read, 0);
    chk("dwr_mem_addr", a_mem_addr, 28'h0000123);
    chk("dwr_mem_wdata", a_mem_wdata, L_WD);
    wait_a(20, n, gi, gd);
    chk("dwr_latency", n, 5);
    chk("dwr_readys", {gi, gd}, 2'b01);
    chk("dwr_i_rdata_hold", a_i_rdata, L_DEAD);
    a_d_write = 0;
    @(negedge clk);

    // tie with fixed D priority
    a_rd = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    a_i_read = 1; a_i_addr = 28'h0000200;
    a_d_read = 1; a_d_addr = 28'h0000300;
    @(negedge clk);
    chk("tie_first_addr", a_mem_addr, 28'h0000300);
    wait_a(20, n, gi, gd);
    chk("tie_first_readys", {gi, gd}, 2'b01);
    a_d_read = 0;
    @(negedge clk);
    chk("tie_gap_mem_read", a_mem_read, 0);
    @(negedge clk);
    chk("tie_second_mem_read", a_mem_read, 1);
    chk("tie_second_addr", a_mem_addr, 28'h0000200);
    wait_a(20, n, gi, gd);
    chk("tie_second_readys", {gi, gd}, 2'b10);
    chk("tie_second_rdata", a_i_rdata, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    a_i_read = 0;
    @(negedge clk);

    // spurious mem_ready in IDLE, then I read+write treated as write
    a_force = 1'b1;
    @(negedge clk);
    a_force = 1'b0;
    chk("spur_readys", {a_i_ready, a_d_ready}, 0);
    chk("spur_mem_req", {a_mem_read, a_mem_write}, 0);
    a_i_read = 1; a_i_write = 1; a_i_addr = 28'h0000055;
    a_i_wdata = 128'hCAFEF00D_00000000_00000000_CAFEF00D;
    @(negedge clk);
    chk("rw_mem_req", {a_mem_read, a_mem_write}, 2'b01);
    chk("rw_mem_wdata", a_mem_wdata, 128'hCAFEF00D_00000000_00000000_CAFEF00D);
    wait_a(20, n, gi, gd);
    chk("rw_readys", {gi, gd}, 2'b10);
    a_i_read = 0; a_i_write = 0;
    @(negedge clk);

    // async reset in the middle of BUSY
    a_auto = 1'b0;
    a_d_read = 1; a_d_addr = 28'h0000077;
    @(negedge clk);
    chk("mrst_busy_req", a_mem_read, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_mem_read", a_mem_read, 0);
    chk("mrst_mem_addr", a_mem_addr, 0);
    chk("mrst_i_rdata", a_i_rdata, 0);
    chk("mrst_d_rdata", a_d_rdata, 0);
    a_d_read = 0;
    @(negedge clk);
    rst_n = 1'b1; a_auto = 1'b1;
    @(negedge clk);
    a_rd = 128'h10101010_20202020_30303030_40404040;
    a_d_read = 1; a_d_addr = 28'h0000010;
    @(negedge clk);
    chk("prst_mem_read", a_mem_read, 1);
    chk("prst_mem_addr", a_mem_addr, 28'h0000010);
    wait_a(20, n, gi, gd);
    chk("prst_latency", n, 5);
    chk("prst_readys", {gi, gd}, 2'b01);
    chk("prst_d_rdata", a_d_rdata, 128'h10101010_20202020_30303030_40404040);
    a_d_read = 0;
    @(negedge clk);

    // round-robin on instance B: both hold requests continuously
    b_i_read = 1; b_i_addr = 28'h0000001;
    b_d_read = 1; b_d_addr = 28'h0000002;
    ni = 0; nd = 0;
    for (int g = 0; g < 4; g++) begin
      who = 2'd2;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (b_i_ready || b_d_ready) begin
          who = b_d_ready ? 2'd1 : 2'd0;
          break;
        end
      end
      if (who == 2'd1) nd++;
      if (who == 2'd0) ni++;
      chk("rr_grant", who, (g % 2 == 0) ? 2'd1 : 2'd0);
    end
    b_i_read = 0; b_d_read = 0;
    chk("rr_count_i", ni, 2);
    chk("rr_count_d", nd, 2);
    chk("rr_d_rdata", b_d_rdata, 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Sits between the CHIP's two L1 miss ports (I-side, D-side) and a single shared slow_memory instance.
- Merges the two 128-bit line-request streams onto one memory port.
- Arbitrates when both sides request, forwards address/data, and routes the read line and ready pulse back to the winner.
- Lets the L2 build share one backing memory for instruction and data traffic.

Parameters:
- ADDR_W, 28, line address width (byte address bits 31:4)
- LINE_W, 128, cache line width in bits
- D_PRIORITY, 1, 1 = fixed D-over-I priority; 0 = round-robin on ties

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-side line read request, held until i_ready
- i_write  in  1  I-side line write request, held until i_ready
- i_addr  in  ADDR_W  I-side line address
- i_wdata  in  LINE_W  I-side write line
- i_rdata  out  LINE_W  I-side returned line, valid when i_ready=1
- i_ready  out  1  one-cycle completion pulse to I-side
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: D-side equivalents, same widths and directions as the I-side ports
- mem_read  out  1  to slow memory, held until mem_ready
- mem_write  out  1  to slow memory, held until mem_ready
- mem_addr  out  ADDR_W  to slow memory
- mem_wdata  out  LINE_W  to slow memory
- mem_rdata  in  LINE_W  from slow memory, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse from slow memory

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=IDLE; last_grant=I; latched addr/wdata=0. Applies immediately, including mid-transaction; the in-flight memory access is abandoned, and the memory model must tolerate request deassertion.
- All outputs are registered; no combinational path from any input to any output.
- A client request is pending when read|write=1. If read and write are both 1, the request is treated as a write.

FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Else pick a winner: only one pending → that client. Both pending → D if D_PRIORITY=1; otherwise the client opposite last_grant.
  - At the edge: latch winner id, addr, wdata and op; set mem_read/mem_write (exactly one high), mem_addr, mem_wdata; update last_grant; go to BUSY.
- BUSY:
  - mem_* outputs held stable.
  - Loser requests are ignored (they stay pending).
  - When mem_ready=1: capture mem_rdata into the winner's rdata register; assert the winner's ready for the next cycle; drop mem_read/mem_write; go to RESP.
  - A write also returns ready; rdata is still captured and its value is don't-care.
- RESP:
  - Winner's ready=1 for exactly this cycle; the other ready stays 0.
  - All requests ignored this cycle, because the winner's request is still high.
  - Next state IDLE; ready returns to 0.
- Latency:
  - Request seen in IDLE at edge k → mem_read high in cycle k+1.
  - mem_ready at edge n → client ready in cycle n+1.
  - Minimum gap between two memory requests is 2 cycles (RESP, then IDLE).
- Non-winner rdata holds its last value; rdata outputs change only on capture.
- mem_ready while in IDLE or RESP is ignored.
- A request that appears and vanishes within IDLE before being sampled is not forwarded.
- Starvation: with D_PRIORITY=0, each client waits at most one other transaction.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY → all outputs 0 immediately; after release, a new d_read to 0x0000010 is forwarded correctly.
- Single I read: i_read=1, i_addr=0x0000040; memory returns 0xDEADBEEF_… after 5 cycles → mem_addr=0x0000040, i_rdata matches, i_ready pulses 1 cycle one cycle after mem_ready, d_ready stays 0.
- D write: d_write=1, d_addr=0x0000123, d_wdata=0x1111…_2222 → mem_write=1, mem_wdata equal to d_wdata, mem_read=0, d_ready pulse, i_rdata unchanged.
- Tie with D_PRIORITY=1: i_read and d_read raised in the same cycle → D served first; I served next with mem_read re-raised 2 cycles after d_ready.
- Tie with D_PRIORITY=0: both clients continuously re-request 4 times → grants alternate D,I,D,I from reset (last_grant=I); the I/D request counts are equal.
- Read and write both high on the I-side, plus a spurious mem_ready while IDLE → forwarded as a write; the spurious ready produces no client ready.
